// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder: snapshots a frame of active-low 7-segment patterns and decodes one digit per clock into nibbles with blank/error masks.
// Ports: clk, reset (sync, active-high), start (capture request, IDLE only), seg_in (digit i at [7i+6:7i], bit0=a..bit6=g),
//        digits (nibble i at [4i+3:4i]), blank_mask, err_mask, valid (one-cycle done pulse), busy (SCAN or DONE).
// Define HEX_ALPHA_EN to decode A,b,C,d,E,F as 4'hA..4'hF; otherwise those patterns are flagged as errors.
module seg7_frame_decoder #(
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    valid,
  output logic                    busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);
  logic [1:0]              state;
  logic [2:0]              idx;
  logic [7*NUM_DIGITS-1:0] snapshot;
  logic [6:0]              cur;
  logic [3:0]              nib;
  logic                    blank;
  logic                    err;
  assign cur   = snapshot[7*idx +: 7];
  assign valid = state == DONE;
  assign busy  = state != IDLE;
  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    err   = 1'b0;
    case (cur)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
`ifdef HEX_ALPHA_EN
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
`endif
      7'h7F: blank = 1'b1;
      default: err = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      snapshot   <= '1;
      digits     <= '0;
      blank_mask <= '0;
      err_mask   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          snapshot   <= seg_in;
          digits     <= '0;
          blank_mask <= '0;
          err_mask   <= '0;
          idx        <= '0;
          state      <= SCAN;
        end
        SCAN: begin
          digits[4*idx +: 4] <= nib;
          blank_mask[idx]    <= blank;
          err_mask[idx]      <= err;
          idx                <= idx + 3'd1;
          if (idx == LAST) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seg7_frame_decoder.sv
// tb_seg7_frame_decoder: directed self-checking bench for seg7_frame_decoder.
module tb_seg7_frame_decoder;
  localparam int N = 6;
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [7*N-1:0] seg_in = '1;
  logic [4*N-1:0] digits;
  logic [N-1:0]   blank_mask;
  logic [N-1:0]   err_mask;
  logic           valid;
  logic           busy;
  int checks = 0;
  int errors = 0;
  localparam logic [41:0] F_942710 = {7'h10, 7'h19, 7'h24, 7'h78, 7'h79, 7'h40};
  localparam logic [41:0] F_8BLANK = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h7F};
  localparam logic [41:0] F_BADSEG = {7'h40, 7'h40, 7'h40, 7'h7E, 7'h40, 7'h40};
  localparam logic [41:0] F_ALPHA  = {7'h40, 7'h40, 7'h08, 7'h40, 7'h40, 7'h40};
  seg7_frame_decoder #(.NUM_DIGITS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .seg_in(seg_in), .digits(digits),
    .blank_mask(blank_mask), .err_mask(err_mask), .valid(valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_frame(input logic [41:0] s);
    seg_in = s;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask
  task automatic wait_valid(output int n, output int busy_cycles);
    n = 0;
    busy_cycles = busy ? 1 : 0;
    while (!valid && n < 20) begin
      tick();
      n++;
      busy_cycles += busy ? 1 : 0;
    end
    check("valid_seen", 32'(valid), 32'd1);
  endtask
  task automatic frame(input string tag, input logic [41:0] s, input logic [23:0] d, input logic [5:0] b, input logic [5:0] e);
    int n, bc;
    start_frame(s);
    wait_valid(n, bc);
    check({tag, "_lat"}, n, 6);
    check({tag, "_digits"}, 32'(digits), 32'(d));
    check({tag, "_blank"}, 32'(blank_mask), 32'(b));
    check({tag, "_err"}, 32'(err_mask), 32'(e));
    tick();
    check({tag, "_valid_drop"}, 32'(valid), 32'd0);
  endtask
  initial begin
    int n, bc, pulses;
    logic [23:0] got;
    repeat (3) tick();
    check("rst_digits", 32'(digits), 32'd0);
    check("rst_masks", 32'({blank_mask, err_mask}), 32'd0);
    check("rst_valid_busy", 32'({valid, busy}), 32'd0);
    reset = 1'b0;
    tick();
    start_frame(F_942710);
    wait_valid(n, bc);
    check("f1_latency", n, 6);
    check("f1_digits", 32'(digits), 32'h942710);
    check("f1_blank", 32'(blank_mask), 32'd0);
    check("f1_err", 32'(err_mask), 32'd0);
    tick();
    check("f1_after", 32'({valid, busy}), 32'd0);
    check("f1_busy_cycles", bc, 7);
    frame("blank", F_8BLANK, 24'h888880, 6'b000001, 6'b000000);
    frame("badseg", F_BADSEG, 24'h000000, 6'b000000, 6'b000100);
`ifdef HEX_ALPHA_EN
    frame("alpha", F_ALPHA, 24'h00A000, 6'b000000, 6'b000000);
`else
    frame("alpha", F_ALPHA, 24'h000000, 6'b000000, 6'b001000);
`endif
    start_frame(F_942710);
    seg_in = F_8BLANK;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    got = '0;
    for (int i = 0; i < 12; i++) begin
      if (valid) begin
        pulses++;
        got = digits;
      end
      tick();
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_digits", 32'(got), 32'h942710);
    start_frame(F_8BLANK);
    wait_valid(n, bc);
    check("b2b_first", 32'(digits), 32'h888880);
    tick();
    start_frame(F_942710);
    wait_valid(n, bc);
    check("b2b_lat", n, 6);
    check("b2b_digits", 32'(digits), 32'h942710);
    tick();
    start_frame(F_8BLANK);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_state", 32'({valid, busy}), 32'd0);
    check("abort_outs", 32'({digits, blank_mask, err_mask}), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid) pulses++;
      tick();
    end
    check("abort_no_valid", pulses, 0);
    frame("post_abort", F_8BLANK, 24'h888880, 6'b000001, 6'b000000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
